onehot_encoder4x2: RTL and testbench
====================================

ONEHOT_ENCODER4X2 -- requirements
Module: onehot_encoder4x2

Interface
REQ-001 Parameter: CNT_W, 8, width of the saturating error counter (legal range 1..16).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: in_valid  input  1  upstream holds a valid code this cycle.
REQ-005 Port: in_ready  output  1  block can accept a code this cycle.
REQ-006 Port: in_code  input  4  one-hot code to encode back to binary index.
REQ-007 Port: prio_mode  input  1  0 = strict one-hot check; 1 = highest-set-bit priority.
REQ-008 Port: out_valid  output  1  head entry is presented on out_idx/out_err.
REQ-009 Port: out_ready  input  1  downstream takes the head entry this cycle.
REQ-010 Port: out_idx  output  2  binary index of the head entry.
REQ-011 Port: out_err  output  1  head entry came from an illegal code.
REQ-012 Port: err_count  output  CNT_W  number of accepted illegal codes, saturating.

Function
REQ-013 A transfer in occurs when in_valid and in_ready are both 1 at a rising edge; prio_mode is sampled on the same edge.
REQ-014 A transfer out occurs when out_valid and out_ready are both 1 at a rising edge.
REQ-015 Storage is a 2-entry FIFO of {idx[1:0], err}; occupancy 0, 1 or 2.
REQ-016 in_ready is 1 exactly when occupancy < 2 and rst is 0; a pop in the same cycle does not raise in_ready while full.
REQ-017 out_valid is 1 exactly when occupancy > 0.
REQ-018 Latency: code accepted at edge N is visible on out_valid/out_idx after edge N (when FIFO was empty); no combinational path from in_* to out_*.
REQ-019 Strict mode, exactly one bit set: idx = position of that bit (0001->0, 0010->1, 0100->2, 1000->3), err = 0.
REQ-020 Strict mode, zero or multiple bits set: idx = 0, err = 1.
REQ-021 Priority mode: idx = position of highest set bit, err = 0; in_code = 0000 gives idx = 0, err = 1.
REQ-022 Simultaneous push and pop: occupancy 1 stays 1 (head replaced by new entry); occupancy 2 cannot push.
REQ-023 Push at occupancy 0 or 1 with no pop: occupancy +1; pop with no push: occupancy -1, next entry becomes head in order.
REQ-024 While out_valid = 1 and out_ready = 0, out_idx and out_err hold unchanged.
REQ-025 When out_valid = 0, out_idx = 0 and out_err = 0.
REQ-026 err_count increments by 1 on every transfer in whose encoded err = 1; it saturates at 2^CNT_W-1 and does not wrap.
REQ-027 err_count counts at acceptance, independent of whether the entry is later popped.
REQ-028 Behaviour with in_valid = 0 or out_ready = 0: no state change other than stated above; in_code is ignored.

Reset
REQ-029 With rst = 1 at a rising edge: occupancy = 0, out_valid = 0, out_idx = 0, out_err = 0, err_count = 0 after that edge.
REQ-030 rst = 1 overrides any simultaneous transfer in or out; that transfer is discarded and not counted.
REQ-031 in_ready is 0 while rst = 1 and 1 in the first cycle after rst deasserts.
REQ-032 Reset mid-operation discards all buffered entries; no stale entry appears after reset.

Verification
REQ-033 Strict, out_ready = 1: stream 0001,0010,0100,1000 -> out_idx 0,1,2,3 one cycle later each, out_err 0, err_count 0.
REQ-034 Strict: in_code 0110 then 0000 -> two entries idx 0 err 1; err_count = 2.
REQ-035 Priority: in_code 0110 -> idx 2 err 0; in_code 1011 -> idx 3 err 0; in_code 0000 -> idx 0 err 1, err_count +1.
REQ-036 Backpressure: out_ready = 0, push 0001,0100 -> in_ready 0 after second push, third code not accepted, out_idx held 0; raise out_ready -> 0 then 2 delivered in order, in_ready returns 1.
REQ-037 CNT_W = 2, strict, push 5 codes of 0000 -> err_count 1,2,3,3,3 (saturates at 3).
REQ-038 Two entries buffered, err_count = 1, assert rst one cycle -> out_valid 0, out_idx 0, err_count 0; next code 1000 emerges as idx 3 only.

Source files
------------

// File: rtl/onehot_encoder4x2.sv
// -----------------------------------------------------------------------------
// onehot_encoder4x2
//
// Converts a 4-bit one-hot code into its 2-bit binary index. Each result is
// buffered in a 2-entry FIFO with valid/ready handshakes on both sides. Every
// accepted illegal code is counted in a saturating error counter.
//
// Encoding rules:
//   prio_mode = 0 (strict)   : exactly one bit set -> idx = its position,
//                              err = 0; zero or several bits -> idx 0, err 1.
//   prio_mode = 1 (priority) : idx = highest set bit, err = 0;
//                              in_code 0000 -> idx 0, err 1.
//
// Ports:
//   clk        in   single clock, rising-edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   upstream presents a code
//   in_ready   out  block can accept a code (occupancy < 2, not in reset)
//   in_code    in   4-bit one-hot code
//   prio_mode  in   0 = strict check, 1 = highest-set-bit priority
//   out_valid  out  head entry is presented
//   out_ready  in   downstream takes the head entry
//   out_idx    out  head entry index (0 when out_valid = 0)
//   out_err    out  head entry came from an illegal code (0 when empty)
//   err_count  out  accepted illegal codes, saturating at 2^CNT_W-1
// -----------------------------------------------------------------------------
module onehot_encoder4x2 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_code,
  input  logic             prio_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_idx,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  typedef struct packed {
    logic [1:0] idx;
    logic       err;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Slot 0 is always the head; slot 1 is valid only at occupancy 2.
  logic [1:0]       occ_q, occ_d;
  entry_t           slot0_q, slot0_d;
  entry_t           slot1_q, slot1_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  entry_t enc_entry;
  logic   push;
  logic   pop;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  // NOTE: every field gets a default before the branches, so no path through
  // the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    enc_entry.idx = 2'd0;
    enc_entry.err = 1'b1;
    if (prio_mode) begin
      if (in_code[3]) begin
        enc_entry.idx = 2'd3;
        enc_entry.err = 1'b0;
      end else if (in_code[2]) begin
        enc_entry.idx = 2'd2;
        enc_entry.err = 1'b0;
      end else if (in_code[1]) begin
        enc_entry.idx = 2'd1;
        enc_entry.err = 1'b0;
      end else if (in_code[0]) begin
        enc_entry.idx = 2'd0;
        enc_entry.err = 1'b0;
      end
    end else begin
      case (in_code)
        4'b0001: begin enc_entry.idx = 2'd0; enc_entry.err = 1'b0; end
        4'b0010: begin enc_entry.idx = 2'd1; enc_entry.err = 1'b0; end
        4'b0100: begin enc_entry.idx = 2'd2; enc_entry.err = 1'b0; end
        4'b1000: begin enc_entry.idx = 2'd3; enc_entry.err = 1'b0; end
        default: begin enc_entry.idx = 2'd0; enc_entry.err = 1'b1; end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // in_ready looks only at registered occupancy, so a pop while full never
  // opens the input in the same cycle. The output side is purely registered,
  // which keeps in_* off any combinational path to out_*.
  assign in_ready  = (occ_q != 2'd2) && !rst;
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_idx   = out_valid ? slot0_q.idx : 2'd0;
  assign out_err   = out_valid ? slot0_q.err : 1'b0;
  assign err_count = err_count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    occ_d       = occ_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    err_count_d = err_count_q;

    case ({push, pop})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) slot0_d = enc_entry;
        else               slot1_d = enc_entry;
      end
      2'b01: begin
        occ_d   = occ_q - 2'd1;
        slot0_d = slot1_q;
      end
      2'b11: begin
        // Push and pop together is only possible at occupancy 1: the
        // departing head is replaced directly by the new entry.
        slot0_d = enc_entry;
      end
      default: ;
    endcase

    if (push && enc_entry.err && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= 2'd0;
      // NOTE: the two storage slots are cleared as well, although out_idx and
      // out_err are already masked by out_valid; it keeps the FIFO contents
      // deterministic after reset at the cost of a few reset connections.
      slot0_q     <= '0;
      slot1_q     <= '0;
      err_count_q <= '0;
    end else begin
      occ_q       <= occ_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_onehot_encoder4x2.sv
// -----------------------------------------------------------------------------
// tb_onehot_encoder4x2
//
// Self-checking bench for onehot_encoder4x2. Two instances share all inputs:
// one with the default 8-bit error counter and one with CNT_W = 2 so that
// saturation is reached quickly. A queue-based reference model tracks the
// FIFO contents and the total number of accepted illegal codes; the expected
// counter values are that total clipped to each instance's maximum.
// -----------------------------------------------------------------------------
module tb_onehot_encoder4x2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_code;
  logic       prio_mode;
  logic       out_ready;

  logic       in_ready_a,  in_ready_b;
  logic       out_valid_a, out_valid_b;
  logic [1:0] out_idx_a,   out_idx_b;
  logic       out_err_a,   out_err_b;
  logic [7:0] err_count_a;
  logic [1:0] err_count_b;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  typedef struct {
    int idx;
    int err;
  } ref_entry_t;

  ref_entry_t ref_q[$];
  int         ref_errs = 0;

  onehot_encoder4x2 #(.CNT_W(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_code   (in_code),
    .prio_mode (prio_mode),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_idx   (out_idx_a),
    .out_err   (out_err_a),
    .err_count (err_count_a)
  );

  onehot_encoder4x2 #(.CNT_W(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_code   (in_code),
    .prio_mode (prio_mode),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_idx   (out_idx_b),
    .out_err   (out_err_b),
    .err_count (err_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference encoding written from the rules: count the set bits, then
  // locate the single / highest one.
  function automatic ref_entry_t ref_encode(input logic [3:0] code, input logic pm);
    ref_entry_t e;
    int hi;
    hi = -1;
    for (int b = 0; b < 4; b++) if (code[b]) hi = b;
    e.idx = 0;
    e.err = 1;
    if (pm) begin
      if (hi >= 0) begin e.idx = hi; e.err = 0; end
    end else if ($countones(code) == 1) begin
      e.idx = hi;
      e.err = 0;
    end
    return e;
  endfunction

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Compare every output of both instances against the model's view of the
  // current state and inputs.
  task automatic check_outputs(input string step);
    int exp_rdy, exp_vld, exp_idx, exp_err;
    exp_rdy = (ref_q.size() < 2 && !rst) ? 1 : 0;
    exp_vld = (ref_q.size() > 0) ? 1 : 0;
    exp_idx = exp_vld ? ref_q[0].idx : 0;
    exp_err = exp_vld ? ref_q[0].err : 0;
    check({step, " in_ready_a"},  16'(in_ready_a),  16'(exp_rdy));
    check({step, " in_ready_b"},  16'(in_ready_b),  16'(exp_rdy));
    check({step, " out_valid_a"}, 16'(out_valid_a), 16'(exp_vld));
    check({step, " out_valid_b"}, 16'(out_valid_b), 16'(exp_vld));
    check({step, " out_idx_a"},   16'(out_idx_a),   16'(exp_idx));
    check({step, " out_idx_b"},   16'(out_idx_b),   16'(exp_idx));
    check({step, " out_err_a"},   16'(out_err_a),   16'(exp_err));
    check({step, " out_err_b"},   16'(out_err_b),   16'(exp_err));
    check({step, " err_count_a"}, 16'(err_count_a), 16'(clip(ref_errs, 255)));
    check({step, " err_count_b"}, 16'(err_count_b), 16'(clip(ref_errs, 3)));
  endtask

  // Advance the model across one rising edge using the driven inputs.
  task automatic model_edge();
    bit         do_push, do_pop;
    ref_entry_t e;
    if (rst) begin
      ref_q.delete();
      ref_errs = 0;
    end else begin
      do_pop  = (ref_q.size() > 0) && out_ready;
      do_push = in_valid && (ref_q.size() < 2);
      e = ref_encode(in_code, prio_mode);
      if (do_pop) void'(ref_q.pop_front());
      if (do_push) begin
        ref_q.push_back(e);
        if (e.err != 0) ref_errs++;
      end
    end
  endtask

  // One clock cycle: drive inputs shortly after an edge, check outputs
  // mid-cycle, then cross the next rising edge and update the model.
  task automatic cycle(input string step, input logic r, input logic iv,
                       input logic [3:0] code, input logic pm, input logic ordy);
    rst       = r;
    in_valid  = iv;
    in_code   = code;
    prio_mode = pm;
    out_ready = ordy;
    #2;
    check_outputs(step);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 4'b0000;
    prio_mode = 1'b0;
    out_ready = 1'b0;

    // Bring both instances out of their unknown power-up state.
    @(posedge clk);
    model_edge();
    #1;

    // Reset state held for a cycle, then released.
    cycle("reset",        1, 0, 4'b0000, 0, 0);
    cycle("post_reset",   0, 0, 4'b0000, 0, 1);

    // Strict stream, downstream always ready.
    cycle("strict_0001",  0, 1, 4'b0001, 0, 1);
    cycle("strict_0010",  0, 1, 4'b0010, 0, 1);
    cycle("strict_0100",  0, 1, 4'b0100, 0, 1);
    cycle("strict_1000",  0, 1, 4'b1000, 0, 1);
    cycle("strict_drain", 0, 0, 4'b0000, 0, 1);

    // Strict illegal codes.
    cycle("strict_0110",  0, 1, 4'b0110, 0, 1);
    cycle("strict_0000",  0, 1, 4'b0000, 0, 1);
    cycle("strict_ill_d", 0, 0, 4'b1111, 0, 1);

    // Priority mode.
    cycle("prio_0110",    0, 1, 4'b0110, 1, 1);
    cycle("prio_1011",    0, 1, 4'b1011, 1, 1);
    cycle("prio_0000",    0, 1, 4'b0000, 1, 1);
    cycle("prio_drain",   0, 0, 4'b0000, 1, 1);

    // Backpressure: fill, attempt a third push, hold, then drain in order.
    cycle("bp_push0",     0, 1, 4'b0001, 0, 0);
    cycle("bp_push1",     0, 1, 4'b0100, 0, 0);
    cycle("bp_full",      0, 1, 4'b1000, 0, 0);
    cycle("bp_hold",      0, 1, 4'b0010, 0, 0);
    cycle("bp_pop0",      0, 0, 4'b0000, 0, 1);
    cycle("bp_pop1",      0, 0, 4'b0000, 0, 1);
    cycle("bp_empty",     0, 0, 4'b0000, 0, 1);

    // Push-and-pop at occupancy 1 keeps one entry, new head.
    cycle("pp_fill",      0, 1, 4'b0010, 0, 0);
    cycle("pp_swap",      0, 1, 4'b1000, 0, 1);
    cycle("pp_drain",     0, 0, 4'b0000, 0, 1);

    // Saturation of the 2-bit counter from a fresh reset.
    cycle("sat_reset",    1, 1, 4'b0000, 0, 1);
    for (int i = 0; i < 6; i++) cycle("sat_push", 0, 1, 4'b0000, 0, 1);
    cycle("sat_idle",     0, 0, 4'b0000, 0, 1);

    // Reset mid-operation with two buffered entries.
    cycle("mid_reset0",   1, 0, 4'b0000, 0, 0);
    cycle("mid_fill0",    0, 1, 4'b0000, 0, 0);
    cycle("mid_fill1",    0, 1, 4'b0100, 0, 0);
    cycle("mid_rst",      1, 1, 4'b0001, 0, 1);
    cycle("mid_after",    0, 1, 4'b1000, 0, 0);
    cycle("mid_head",     0, 0, 4'b0000, 0, 1);
    cycle("mid_empty",    0, 0, 4'b0000, 0, 1);

    // Randomized traffic, biased toward legal one-hot codes.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] code;
      if ($urandom_range(0, 2) == 0) code = 4'($urandom_range(0, 15));
      else                           code = 4'(4'b0001 << $urandom_range(0, 3));
      cycle("random",
            ($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 1)),
            code,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
